clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Reset sequencer and multi-channel clock-enable generator, the parametrised successor to the
//  DCM/PLL reset glue. Filters the PLL lock, holds chip_reset for a programmable time after lock,
//  then releases it and runs NUM_CH independent clock-enable dividers. Sits in top between the PLL
//  and cpu/bus/peripherals; drops back into reset automatically on loss of lock.
// PARAMETERS
//  NUM_CH      4   number of clock-enable channels (>=1)
//  DIV_W       8   divider width per channel
//  LOCK_FILT  16   consecutive synchronised-locked cycles required (>=1)
//  RST_HOLD   32   cycles chip_reset stays high after lock is accepted (>=1)
//  SYNC_STAGES 2   synchroniser depth for locked (>=2)
// PORTS
//  clk            in   1             system clock
//  reset          in   1             asynchronous, active-high reset
//  locked         in   1             PLL lock, asynchronous to clk
//  div_ratio      in   NUM_CH*DIV_W  channel i divisor N in bits [i*DIV_W +: DIV_W]; ce every N+1 cycles
//  lock_lost_clr  in   1             sync pulse, clears lock_lost
//  soft_rst       in   1             sync pulse, re-enter reset hold (only with SOFT_RESET_EN)
//  chip_reset     out  1             active-high system reset, = (state != RUN)
//  run            out  1             = (state == RUN)
//  ce             out  NUM_CH        per-channel one-cycle clock enables
//  lock_lost      out  1             sticky: lock dropped while in RUN
// BEHAVIOUR
//  - Reset (async): state=WAIT_LOCK, sync chain=0, filt/hold/div counters=0, lock_lost=0;
//    outputs chip_reset=1, run=0, ce=0. Deassertion of reset takes effect at the next clk edge.
//  - locked passes SYNC_STAGES flops -> locked_s; nothing else samples locked directly.
//  - FSM (state register, outputs decoded from registered state only, glitch-free):
//    WAIT_LOCK: filt_cnt+=1 while locked_s, cleared to 0 when !locked_s; at filt_cnt==LOCK_FILT-1
//               && locked_s -> HOLD (hold_cnt=0).
//    HOLD:      hold_cnt+=1; !locked_s -> WAIT_LOCK (filt_cnt=0, priority); hold_cnt==RST_HOLD-1 -> RUN.
//    RUN:       !locked_s -> WAIT_LOCK, filt_cnt=0, lock_lost set same edge.
//  - Latency: locked stable high from edge 0 -> chip_reset falls after exactly
//    SYNC_STAGES+LOCK_FILT+RST_HOLD edges (50 with defaults). Lock glitch < LOCK_FILT cycles never
//    releases reset. Lock loss in RUN -> chip_reset high SYNC_STAGES+1 edges later.
//  - Dividers: cnt_i 0..2^DIV_W-1, only in RUN; ce[i] = run && (cnt_i >= div_i) (combinational from
//    registers). In RUN: cnt_i <= (cnt_i >= div_i) ? 0 : cnt_i+1. Outside RUN cnt_i=0, ce=0.
//    First ce[i] on the (div_i+1)-th RUN cycle; div_i=0 -> ce[i] high every RUN cycle.
//    div_ratio changed live below cnt_i: ce[i] fires next cycle and cnt_i wraps to 0 (no 2^DIV_W stall).
//    All channels restart phase-aligned at every RUN entry.
//  - lock_lost: set on RUN->WAIT_LOCK by lock loss; cleared by lock_lost_clr; set wins if same cycle.
//    Not affected by HOLD/WAIT_LOCK lock loss.
// CONFIGURATION
//  SOFT_RESET_EN defined: soft_rst port present; soft_rst high in RUN -> HOLD (hold_cnt=0), so
//    chip_reset high next edge for exactly RST_HOLD cycles, then RUN; ignored in WAIT_LOCK/HOLD;
//    lock loss same cycle takes priority (-> WAIT_LOCK). lock_lost not set by soft_rst.
//  SOFT_RESET_EN undefined: soft_rst port absent; FSM has no RUN->HOLD arc; all else identical.
// TESTING
//  1. reset pulse, locked=1 constant -> chip_reset=1 for 50 edges after reset release, then 0, run=1.
//  2. locked high 10 cycles, low 1, high -> filter restarts; chip_reset falls 50 edges after final rise.
//  3. div_ratio ch0=0,ch1=1,ch2=3,ch3=255 in RUN -> ce periods 1,2,4,256; all first pulses aligned to
//     RUN entry (ch0 at cycle 1, ch1 at 2, ch2 at 4).
//  4. locked drops in RUN -> chip_reset=1 3 edges later, ce=0, lock_lost=1; lock_lost_clr with no
//     new loss -> 0; clr coincident with new loss -> stays 1.
//  5. ch2 div 200, cnt at 150, div changed to 10 -> ce[2] next cycle, then period 11.
//  6. SOFT_RESET_EN: soft_rst pulse in RUN -> chip_reset high exactly 32 cycles, lock_lost stays 0;
//     async reset mid-HOLD -> immediate chip_reset=1, run=0, full 50-edge sequence again.

Source files
------------

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: reset sequencer plus multi-channel clock-enable generator.
// Filters PLL lock, holds chip_reset for RST_HOLD cycles after lock is accepted,
// then releases it and runs NUM_CH independent clock-enable dividers.
// Loss of lock in RUN drops straight back to WAIT_LOCK and sets sticky lock_lost.
//
// Optional feature macro: SOFT_RESET_EN (adds soft_rst port and a RUN->HOLD arc).
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   locked         in   PLL lock, asynchronous to clk
//   div_ratio      in   per-channel divisor N in [i*DIV_W +: DIV_W]; ce every N+1 cycles
//   lock_lost_clr  in   sync pulse, clears lock_lost
//   soft_rst       in   sync pulse, re-enter reset hold (SOFT_RESET_EN only)
//   chip_reset     out  active-high system reset (state != RUN)
//   run            out  state == RUN
//   ce             out  per-channel one-cycle clock enables
//   lock_lost      out  sticky: lock dropped while in RUN
module clk_rst_seq #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned LOCK_FILT   = 16,
    parameter int unsigned RST_HOLD    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    locked,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    lock_lost_clr,
`ifdef SOFT_RESET_EN
    input  logic                    soft_rst,
`endif
    output logic                    chip_reset,
    output logic                    run,
    output logic [NUM_CH-1:0]       ce,
    output logic                    lock_lost
);

    localparam int unsigned FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_locked_s;
    logic [FILT_W-1:0]       r_filt_cnt;
    logic [FILT_W-1:0]       w_filt_nxt;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [HOLD_W-1:0]       w_hold_nxt;
    logic                    w_lost_set;

    // Lock synchroniser; the only place locked is sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_WAIT_LOCK;
            r_filt_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_filt_cnt <= w_filt_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state logic; counters fall back to zero whenever they are not advancing,
    // so every state entry starts with a cleared count.
    always_comb begin
        w_state_nxt = r_state;
        w_filt_nxt  = '0;
        w_hold_nxt  = '0;
        w_lost_set  = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    if (r_filt_cnt == FILT_W'(LOCK_FILT - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_filt_nxt = r_filt_cnt + FILT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_lost_set  = 1'b1;
`ifdef SOFT_RESET_EN
                end else if (soft_rst) begin
                    w_state_nxt = ST_HOLD;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    assign run        = (r_state == ST_RUN);
    assign chip_reset = (r_state != ST_RUN);

    // Sticky lock-loss flag; a new loss wins over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_lost <= 1'b0;
        end else if (w_lost_set) begin
            lock_lost <= 1'b1;
        end else if (lock_lost_clr) begin
            lock_lost <= 1'b0;
        end
    end

    // Per-channel dividers. Using >= rather than == means a divisor lowered below
    // the running count fires on the next cycle instead of waiting for a full wrap.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] w_div;
        logic             w_hit;

        assign w_div = div_ratio[g*DIV_W +: DIV_W];
        assign w_hit = (r_cnt >= w_div);
        assign ce[g] = run && w_hit;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (run) begin
                r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: table-driven lock/divider vectors,
// directed multi-cycle corner sequences, and a randomized run against a
// streak-based behavioural model.
module tb_clk_rst_seq;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int LOCK_FILT   = 16;
    localparam int RST_HOLD    = 32;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + LOCK_FILT + RST_HOLD;
    localparam int FULL        = LOCK_FILT + RST_HOLD;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    locked;
    logic [NUM_CH*DIV_W-1:0] div_ratio;
    logic                    lock_lost_clr;
    logic                    soft_rst;
    logic                    chip_reset;
    logic                    run;
    logic [NUM_CH-1:0]       ce;
    logic                    lock_lost;

    int n_cmp = 0;
    int n_bad = 0;

    clk_rst_seq #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_FILT  (LOCK_FILT),
        .RST_HOLD   (RST_HOLD),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .locked       (locked),
        .div_ratio    (div_ratio),
        .lock_lost_clr(lock_lost_clr),
`ifdef SOFT_RESET_EN
        .soft_rst     (soft_rst),
`endif
        .chip_reset   (chip_reset),
        .run          (run),
        .ce           (ce),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    // {chip_reset, run, ce[3:0], lock_lost}
    function automatic logic [6:0] outs();
        outs = {chip_reset, run, ce, lock_lost};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lk);
        reset         = 1'b1;
        locked        = lk;
        lock_lost_clr = 1'b0;
        soft_rst      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'(7'b1000000));
        reset = 1'b0;
    endtask

    typedef struct {
        int          edges;
        logic        lk;
        logic [31:0] div;
        logic [6:0]  exp;
    } vec_t;

    vec_t tbl[9];

    // Random-phase model state
    int          lq[$];
    int          streak;
    int          rc;
    logic        m_run;
    logic        m_ll;
    int          seg_left;
    logic        seg_val;
    int          ls;
    logic        soft_eff;
    logic        new_run;
    logic [3:0]  exp_ce;
    int          d;

    initial begin
        // RUN entry with divisors ch3..ch0 = 255,3,1,0; exp = {cr, run, ce[3:0], ll}
        tbl[0] = '{49,  1'b1, 32'hFF030100, 7'b1000000};
        tbl[1] = '{1,   1'b1, 32'hFF030100, 7'b0100010};
        tbl[2] = '{1,   1'b1, 32'hFF030100, 7'b0100110};
        tbl[3] = '{1,   1'b1, 32'hFF030100, 7'b0100010};
        tbl[4] = '{1,   1'b1, 32'hFF030100, 7'b0101110};
        tbl[5] = '{1,   1'b1, 32'hFF030100, 7'b0100010};
        tbl[6] = '{251, 1'b1, 32'hFF030100, 7'b0111110};
        tbl[7] = '{1,   1'b1, 32'hFF030100, 7'b0100010};
        tbl[8] = '{255, 1'b1, 32'hFF030100, 7'b0111110};

        div_ratio = 32'hFF030100;
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            locked    = tbl[i].lk;
            div_ratio = tbl[i].div;
            step(tbl[i].edges);
            check($sformatf("tbl[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Lock loss in RUN: still running two edges later, reset on the third.
        locked = 1'b0;
        step(2);
        check("loss_plus2", 32'({chip_reset, run, lock_lost}), 32'(3'b010));
        step(1);
        check("loss_plus3", 32'(outs()), 32'(7'b1000001));
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check("clr_no_loss", 32'(lock_lost), 32'(1'b0));
        locked = 1'b1;
        step(LAT);
        check("reacquire", 32'(outs()), 32'(7'b0100010));
        locked = 1'b0;
        step(2);
        lock_lost_clr = 1'b1;
        step(1);
        lock_lost_clr = 1'b0;
        check("clr_vs_loss", 32'(outs()), 32'(7'b1000001));

        // Live divisor change below the running count.
        div_ratio = 32'hFFC80100;
        locked    = 1'b1;
        step(LAT);
        lock_lost_clr = 1'b1;
        step(150);
        lock_lost_clr = 1'b0;
        check("div200_cnt150", 32'({run, ce[2], lock_lost}), 32'(3'b100));
        div_ratio = 32'hFF0A0100;
        #1;
        check("div_live_fire", 32'(ce[2]), 32'(1'b1));
        step(1);
        check("div_wrap", 32'(ce[2]), 32'(1'b0));
        step(9);
        check("div10_cnt9", 32'(ce[2]), 32'(1'b0));
        step(1);
        check("div10_p1", 32'(ce[2]), 32'(1'b1));
        step(11);
        check("div10_p2", 32'(ce[2]), 32'(1'b1));

`ifdef SOFT_RESET_EN
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_enter", 32'({chip_reset, run, lock_lost}), 32'(3'b100));
        step(RST_HOLD - 1);
        check("soft_hold_end", 32'({chip_reset, run, lock_lost}), 32'(3'b100));
        step(1);
        check("soft_release", 32'({chip_reset, run, lock_lost}), 32'(3'b010));
`endif

        // Async reset while running, then again in HOLD.
        #3;
        reset = 1'b1;
        #1;
        check("async_in_run", 32'(outs()), 32'(7'b1000000));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(30);
        check("in_hold", 32'({chip_reset, run}), 32'(2'b10));
        #3;
        reset = 1'b1;
        #1;
        check("async_in_hold", 32'(outs()), 32'(7'b1000000));
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(LAT - 1);
        check("after_hold_rst_49", 32'({chip_reset, run}), 32'(2'b10));
        step(1);
        check("after_hold_rst_50", 32'({chip_reset, run}), 32'(2'b01));

        // Glitch in lock restarts the filter.
        do_reset(1'b0);
        locked = 1'b1;
        step(10);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(LAT - 1);
        check("glitch_49", 32'({chip_reset, run}), 32'(2'b10));
        step(1);
        check("glitch_50", 32'({chip_reset, run}), 32'(2'b01));

        // Randomized run: run = (consecutive synchronised-high edges) >= LOCK_FILT+RST_HOLD.
        div_ratio = '0;
        do_reset(1'b0);
        lq.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lq.push_back(0);
        streak   = 0;
        rc       = 0;
        m_run    = 1'b0;
        m_ll     = 1'b0;
        seg_left = 0;
        seg_val  = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                seg_val  = !seg_val;
                seg_left = seg_val ? int'($urandom_range(5, 140)) : int'($urandom_range(1, 4));
            end
            seg_left--;
            locked        = seg_val;
            lock_lost_clr = ($urandom_range(0, 19) == 0);
            soft_rst      = ($urandom_range(0, 59) == 0);
            if (!m_run && $urandom_range(0, 9) == 0) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    div_ratio[ch*DIV_W +: DIV_W] = 8'($urandom_range(0, (ch == 3) ? 40 : 6));
                end
            end
            @(posedge clk);
            ls = lq.pop_front();
            lq.push_back(int'(locked));
`ifdef SOFT_RESET_EN
            soft_eff = soft_rst;
`else
            soft_eff = 1'b0;
`endif
            if (m_run && ls == 0) m_ll = 1'b1;
            else if (lock_lost_clr) m_ll = 1'b0;
            if (ls == 0) streak = 0;
            else if (soft_eff && m_run) streak = LOCK_FILT;
            else if (streak < FULL) streak++;
            new_run = (streak >= FULL);
            rc      = new_run ? (m_run ? rc + 1 : 1) : 0;
            m_run   = new_run;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                d          = int'(div_ratio[ch*DIV_W +: DIV_W]);
                exp_ce[ch] = m_run && ((rc % (d + 1)) == 0);
            end
            #1;
            check($sformatf("rand[%0d]", c), 32'(outs()), 32'({!m_run, m_run, exp_ce, m_ll}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
